// File: rtl/alu_op_decoder.sv
// alu_op_decoder: registered RV32I decode stage feeding the ALU and register file.
// It has an output register plus one skid register behind a valid/ready handshake.
// Optional macro ALU_OP_DECODER_SLTU_EN enables decode of SLTU/SLTIU/BLTU/BGEU
// to ALU code 1001. Without it, those four instructions decode as illegal.
`timescale 1ns/1ps

module alu_op_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_ctrl,
    output logic [31:0] out_imm,
    output logic        out_use_imm,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic        out_is_branch,
    output logic        out_branch_inv,
    output logic        out_illegal
);

`ifdef ALU_OP_DECODER_SLTU_EN
    localparam logic SLTU_EN = 1'b1;
`else
    localparam logic SLTU_EN = 1'b0;
`endif

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] imm;
        logic        use_imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        is_branch;
        logic        branch_inv;
        logic        illegal;
    } bundle_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;

    bundle_t dec;
    logic    legal;

    bundle_t out_q;
    bundle_t skid_q;
    logic    out_v_q;
    logic    skid_v_q;
    logic    accept;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};

    // Combinational decode of the incoming instruction word into a bundle.
    always_comb begin
        dec     = '0;
        legal   = 1'b0;
        dec.rd  = in_instr[11:7];
        dec.rs1 = in_instr[19:15];
        dec.rs2 = in_instr[24:20];
        case (opcode)
            OP_R: begin
                legal = (funct7 == F7_ZERO);
                case (funct3)
                    3'b000: begin
                        dec.ctrl = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                        legal    = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    end
                    3'b001: dec.ctrl = ALU_SLL;
                    3'b010: dec.ctrl = ALU_SLT;
                    3'b011: begin
                        dec.ctrl = ALU_SLTU;
                        legal    = SLTU_EN && (funct7 == F7_ZERO);
                    end
                    3'b100: dec.ctrl = ALU_XOR;
                    3'b101: begin
                        dec.ctrl = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        legal    = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    end
                    3'b110: dec.ctrl = ALU_OR;
                    default: dec.ctrl = ALU_AND;
                endcase
            end
            OP_I: begin
                legal       = 1'b1;
                dec.use_imm = 1'b1;
                dec.imm     = imm_i;
                case (funct3)
                    3'b000: dec.ctrl = ALU_ADD;
                    3'b001: begin
                        dec.ctrl = ALU_SLL;
                        legal    = (funct7 == F7_ZERO);
                    end
                    3'b010: dec.ctrl = ALU_SLT;
                    3'b011: begin
                        dec.ctrl = ALU_SLTU;
                        legal    = SLTU_EN;
                    end
                    3'b100: dec.ctrl = ALU_XOR;
                    3'b101: begin
                        dec.ctrl = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        legal    = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    end
                    3'b110: dec.ctrl = ALU_OR;
                    default: dec.ctrl = ALU_AND;
                endcase
            end
            OP_LOAD: begin
                legal       = 1'b1;
                dec.ctrl    = ALU_ADD;
                dec.use_imm = 1'b1;
                dec.imm     = imm_i;
            end
            OP_STORE: begin
                legal       = 1'b1;
                dec.ctrl    = ALU_ADD;
                dec.use_imm = 1'b1;
                dec.imm     = imm_s;
            end
            OP_BRANCH: begin
                legal         = 1'b1;
                dec.is_branch = 1'b1;
                dec.imm       = imm_b;
                // Taken sense is relative to the ALU zero flag:
                // SUB==0 means equal, SLT/SLTU==0 means not-less-than.
                case (funct3)
                    3'b000: dec.ctrl = ALU_SUB;
                    3'b001: begin
                        dec.ctrl       = ALU_SUB;
                        dec.branch_inv = 1'b1;
                    end
                    3'b100: begin
                        dec.ctrl       = ALU_SLT;
                        dec.branch_inv = 1'b1;
                    end
                    3'b101: dec.ctrl = ALU_SLT;
                    3'b110: begin
                        dec.ctrl       = ALU_SLTU;
                        dec.branch_inv = 1'b1;
                        legal          = SLTU_EN;
                    end
                    3'b111: begin
                        dec.ctrl = ALU_SLTU;
                        legal    = SLTU_EN;
                    end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        // Illegal bundles keep the register indices but zero all ALU control.
        if (!legal) begin
            dec.ctrl       = ALU_ADD;
            dec.imm        = '0;
            dec.use_imm    = 1'b0;
            dec.is_branch  = 1'b0;
            dec.branch_inv = 1'b0;
        end
        dec.illegal = ~legal;
    end

    // The skid register only fills while the output is stalled, so in_ready is
    // simply "skid empty". This keeps in_ready a pure flop output.
    assign accept = in_valid & ~skid_v_q;

    // Output and skid storage; the skid drains into the output when it fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            skid_q   <= '0;
            out_v_q  <= 1'b0;
            skid_v_q <= 1'b0;
        end else if (skid_v_q) begin
            if (out_ready) begin
                out_q    <= skid_q;
                skid_v_q <= 1'b0;
            end
        end else if (accept) begin
            if (!out_v_q || out_ready) begin
                out_q   <= dec;
                out_v_q <= 1'b1;
            end else begin
                skid_q   <= dec;
                skid_v_q <= 1'b1;
            end
        end else if (out_ready) begin
            out_v_q <= 1'b0;
        end
    end

    assign in_ready       = ~skid_v_q;
    assign out_valid      = out_v_q;
    assign out_ctrl       = out_q.ctrl;
    assign out_imm        = out_q.imm;
    assign out_use_imm    = out_q.use_imm;
    assign out_rd         = out_q.rd;
    assign out_rs1        = out_q.rs1;
    assign out_rs2        = out_q.rs2;
    assign out_is_branch  = out_q.is_branch;
    assign out_branch_inv = out_q.branch_inv;
    assign out_illegal    = out_q.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Bench for alu_op_decoder: a reference decoder feeds a FIFO-order scoreboard
// that is compared every cycle, with directed literal checks alongside it.
`timescale 1ns/1ps

module tb_alu_op_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_ctrl;
    logic [31:0] out_imm;
    logic        out_use_imm;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic        out_is_branch;
    logic        out_branch_inv;
    logic        out_illegal;

    alu_op_decoder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_imm(out_imm), .out_use_imm(out_use_imm),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_is_branch(out_is_branch), .out_branch_inv(out_branch_inv),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

`ifdef ALU_OP_DECODER_SLTU_EN
    localparam bit SLTU_ON = 1'b1;
`else
    localparam bit SLTU_ON = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] imm;
        logic        use_imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        is_branch;
        logic        inv;
        logic        illegal;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    int   pops = 0;
    exp_t q[$];
    exp_t act;

    assign act = {out_ctrl, out_imm, out_use_imm, out_rd, out_rs1, out_rs2,
                  out_is_branch, out_branch_inv, out_illegal};

    // ALU code per funct3 for the base (funct7=0) R/I operations.
    logic [3:0]  alu_tab [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    logic [31:0] vecs [10] = '{32'hFFC12283, 32'hFE512C23, 32'h40315093, 32'h40311093,
                               32'h0020A463, 32'h0020F463, 32'h4020D1B3, 32'h0020F1B3,
                               32'h022081B3, 32'hFE000EE3};

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] c, input logic [31:0] imm, input logic u,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic br, input logic inv, input logic ill);
        exp_t e;
        e = {c, imm, u, rd, rs1, rs2, br, inv, ill};
        return e;
    endfunction

    // Reference decoder working from instruction semantics.
    function automatic exp_t model(input logic [31:0] i);
        exp_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] code;
        bit         ok;
        int         v;
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        e = '0;
        e.rd = i[11:7];
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        ok = 1'b0;
        code = 4'd0;
        if (op == 7'h33) begin
            code = alu_tab[f3];
            ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            if (f7 == 7'h20) code = code + 4'd1;
        end else if (op == 7'h13) begin
            code = alu_tab[f3];
            if (f3 == 3'd1) ok = (f7 == 7'h00);
            else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
            else ok = 1'b1;
            if (f3 == 3'd5 && f7 == 7'h20) code = code + 4'd1;
            v = $signed(i[31:20]);
            e.imm = v;
            e.use_imm = 1'b1;
        end else if (op == 7'h03 || op == 7'h23) begin
            ok = 1'b1;
            v = (op == 7'h03) ? $signed(i[31:20]) : $signed({i[31:25], i[11:7]});
            e.imm = v;
            e.use_imm = 1'b1;
        end else if (op == 7'h63) begin
            ok = (f3[2:1] != 2'b01);
            code = f3[2] ? (f3[1] ? 4'd9 : 4'd8) : 4'd1;
            e.inv = f3[0] ^ f3[2];
            e.is_branch = 1'b1;
            v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
            e.imm = v;
        end
        if (code == 4'd9 && !SLTU_ON) ok = 1'b0;
        e.ctrl = code;
        if (!ok) begin
            e.ctrl = '0;
            e.imm = '0;
            e.use_imm = 1'b0;
            e.is_branch = 1'b0;
            e.inv = 1'b0;
        end
        e.illegal = !ok;
        return e;
    endfunction

    // Scoreboard: at most two bundles in flight, FIFO order.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            bit f, a;
            f = (q.size() > 0) && out_ready;
            a = in_valid && (q.size() < 2);
            if (f) begin
                void'(q.pop_front());
                pops++;
            end
            if (a) q.push_back(model(in_instr));
        end
    end

    // Per-cycle comparison against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
            if (out_valid && q.size() > 0) chk("bundle", 64'(act), 64'(q[0]));
        end
    end

    task automatic push(input logic [31:0] instr);
        bit r;
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_instr = instr;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) begin
                done = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        chk("accept_timeout", 64'(done), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=running want=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int p0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_bundle", 64'(act), 64'd0);

        // Pin the reference decoder with hand-decoded words.
        chk("m_add", 64'(model(32'h002081B3)), 64'(mk(4'd0, 32'h0, 1'b0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0)));
        chk("m_sub", 64'(model(32'h402081B3)), 64'(mk(4'd1, 32'h0, 1'b0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0)));
        chk("m_addi", 64'(model(32'hFFF00093)), 64'(mk(4'd0, 32'hFFFFFFFF, 1'b1, 5'd1, 5'd0, 5'd31, 1'b0, 1'b0, 1'b0)));
        chk("m_bne", 64'(model(32'h00209463)), 64'(mk(4'd1, 32'h8, 1'b0, 5'd8, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0)));
        chk("m_sw", 64'(model(32'hFE512C23)), 64'(mk(4'd0, 32'hFFFFFFF8, 1'b1, 5'd24, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0)));
        chk("m_lui", 64'(model(32'h000010B7)), 64'(mk(4'd0, 32'h0, 1'b0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1)));
        if (SLTU_ON)
            chk("m_sltu", 64'(model(32'h0020B1B3)), 64'(mk(4'd9, 32'h0, 1'b0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0)));
        else
            chk("m_sltu", 64'(model(32'h0020B1B3)), 64'(mk(4'd0, 32'h0, 1'b0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1)));

        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        push(32'h002081B3);
        chk("add_valid", 64'(out_valid), 64'd1);
        chk("add_ctrl", 64'(out_ctrl), 64'd0);
        chk("add_regs", 64'({out_rd, out_rs1, out_rs2}), 64'({5'd3, 5'd1, 5'd2}));
        chk("add_flags", 64'({out_use_imm, out_illegal}), 64'd0);

        in_valid = 1'b1;
        in_instr = 32'h402081B3;
        @(posedge clk);
        #1;
        chk("b2b_sub_ctrl", 64'(out_ctrl), 64'd1);
        in_instr = 32'hFFF00093;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("b2b_addi_valid", 64'(out_valid), 64'd1);
        chk("b2b_addi", 64'({out_ctrl, out_use_imm, out_imm, out_rd}),
            64'({4'd0, 1'b1, 32'hFFFFFFFF, 5'd1}));

        push(32'h00209463);
        chk("bne", 64'({out_is_branch, out_ctrl, out_branch_inv, out_imm}),
            64'({1'b1, 4'd1, 1'b1, 32'h8}));

        push(32'h0020B1B3);
        if (SLTU_ON) chk("sltu", 64'({out_ctrl, out_illegal}), 64'({4'd9, 1'b0}));
        else         chk("sltu", 64'({out_ctrl, out_illegal}), 64'({4'd0, 1'b1}));

        push(32'h000010B7);
        chk("lui_illegal", 64'(out_illegal), 64'd1);

        for (int k = 0; k < 10; k++) begin
            out_ready = (k % 3) != 0;
            push(vecs[k]);
        end
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Stall: first held, second in skid, third waits.
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        p0 = pops;
        push(32'h00A00513);
        push(32'h40B505B3);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_hold_ctrl", 64'({out_valid, out_ctrl, out_rd}), 64'({1'b1, 4'd0, 5'd10}));
        fork
            push(32'h00C5F633);
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("stall_still_blocked", 64'(in_ready), 64'd0);
                chk("stall_still_held", 64'(out_rd), 64'd10);
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("stall_emitted", 64'(pops - p0), 64'd3);
        chk("stall_drained", 64'(out_valid), 64'd0);

        // Async reset with skid full.
        out_ready = 1'b0;
        push(32'h00100093);
        push(32'h00200113);
        chk("pre_rst_full", 64'(in_ready), 64'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_bundle", 64'(act), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_empty", 64'(out_valid), 64'd0);
        push(32'h0020F1B3);
        chk("post_rst_and", 64'({out_valid, out_ctrl}), 64'({1'b1, 4'd2}));
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_op_decoder.md
# alu_op_decoder

Registered instruction-to-ALU decode stage that produces the 4-bit ALU operation code, immediate and register fields consumed by the ALU and register file. It sits between instruction fetch and execute, accepts one RV32I instruction per cycle over a valid/ready handshake, and buffers up to two decoded results in a skid buffer so back-pressure from execute never drops an instruction.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_instr valid
- in_ready  out  1  decoder can accept; registered
- in_instr  in  32  raw instruction word
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_ctrl  out  4  ALU code: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU (macro only)
- out_imm  out  32  sign-extended immediate
- out_use_imm  out  1  ALU B operand is out_imm
- out_rd / out_rs1 / out_rs2  out  5 each  register indices, instr[11:7]/[19:15]/[24:20]
- out_is_branch  out  1  conditional branch
- out_branch_inv  out  1  branch taken when ALU zero==0 (else when zero==1)
- out_illegal  out  1  instruction not decodable

## Operation
- Opcode 0110011 (R): funct3/funct7 map to ADD/SUB (funct7 0000000/0100000), SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND; any other funct7 -> illegal. use_imm=0.
- Opcode 0010011 (I-ALU): ADDI, SLTI, SLTIU, XORI, ORI, ANDI; SLLI needs funct7=0, SRLI/SRAI need 0000000/0100000, else illegal. use_imm=1, imm=sext(instr[31:20]).
- Opcode 0000011 (load) and 0100011 (store): ctrl=ADD, use_imm=1; load imm I-type, store imm sext({instr[31:25],instr[11:7]}).
- Opcode 1100011 (branch): is_branch=1, use_imm=0, out_imm=B-type sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}). BEQ: SUB, inv=0; BNE: SUB, inv=1; BLT: SLT, inv=1; BGE: SLT, inv=0; BLTU/BGEU: SLTU with inv 1/0; funct3 010/011 illegal.
- Any other opcode: illegal=1.
- Illegal bundles: ctrl=0000, use_imm=0, is_branch=0, branch_inv=0, imm=0; still pass through the handshake.
- Storage: output register plus one skid register. Skid-register contents move to the output register when output fires.

## Timing
- Reset (async, immediate): out_valid=0, in_ready=1, all other outputs 0, skid empty.
- Input transfer when in_valid&in_ready at a rising edge; output transfer when out_valid&out_ready.
- Latency: accepted at edge k -> out_valid=1 with decoded bundle after edge k. Throughput 1/cycle with out_ready held high.
- Output empty, or firing this edge, with skid empty: new bundle loads output register.
- Output valid and stalled while accepting: new bundle loads skid; in_ready=0 after that edge.
- Skid full and output fires: skid moves to output, in_ready=1 after that edge; nothing accepted on that edge, because in_ready was 0.
- Output bundle stable while out_valid&~out_ready.
- Reset mid-stream discards both entries; no bundle is emitted after reset release until a new accept.

## Configuration
- ALU_OP_DECODER_SLTU_EN defined: SLTU, SLTIU, BLTU and BGEU decode to ctrl=1001 as above. The ALU must implement 1001 as unsigned less-than.
- Undefined: those four instructions set out_illegal=1 and use the illegal bundle defaults; code 1001 is never emitted.

## Test plan
- 0x002081B3 (ADD x3,x1,x2), out_ready=1 -> next cycle ctrl=0000, rd=3, rs1=1, rs2=2, use_imm=0, illegal=0.
- 0x402081B3 then 0xFFF00093 back-to-back -> ctrl=0001, then ctrl=0000, use_imm=1, imm=0xFFFFFFFF, rd=1, on consecutive cycles.
- 0x00209463 (BNE +8) -> is_branch=1, ctrl=0001, branch_inv=1, imm=0x00000008.
- 0x0020B1B3 (SLTU) -> with macro ctrl=1001, illegal=0; without macro illegal=1, ctrl=0000. Also 0x000010B7 (LUI) -> illegal=1.
- out_ready=0, three instructions offered each cycle -> first held on output, second in skid, in_ready=0, third waits. Raise out_ready -> all three emitted in order, none lost or duplicated.
- Assert rst_n=0 with skid full -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.
